// File: rtl/mux_pkg.sv
// Shared constants and helpers for the bit-select multiplexer family.
//   MUX_N_IN_DEFAULT  : default number of data inputs
//   MUX_SEL_W_DEFAULT : default select width
//   mux_sel_width()   : ceil(log2(n)), the select width a given N_IN requires
package mux_pkg;

  localparam int unsigned MUX_N_IN_DEFAULT  = 16;
  localparam int unsigned MUX_SEL_W_DEFAULT = 4;

  function automatic int unsigned mux_sel_width(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/mux_tree.sv
// Balanced binary tree of 2:1 muxes selecting one bit of a packed word.
// Ports:
//   in      [N_IN-1:0]  packed data word, bit i is data input i
//   sel     [SEL_W-1:0] index of the bit to route
//   out                 selected bit, 0 when sel is out of range
//   sel_err             high when sel >= N_IN
module mux_tree #(
  parameter int unsigned N_IN  = 16,
  parameter int unsigned SEL_W = 4
) (
  input  logic [N_IN-1:0]  in,
  input  logic [SEL_W-1:0] sel,
  output logic             out,
  output logic             sel_err
);

  localparam int unsigned    LEAVES = 32'd1 << SEL_W;
  localparam logic [SEL_W:0] N_LIM  = (SEL_W + 1)'(N_IN);

  // Level 0 holds the leaves (input padded with zeros up to a power of two);
  // level l halves the width using sel[l-1], so level SEL_W is the root.
  for (genvar l = 0; l <= SEL_W; l++) begin : g_lvl
    logic [(LEAVES >> l)-1:0] v;
    if (l == 0) begin : g_leaf
      if (N_IN == LEAVES) begin : g_full
        assign v = in;
      end else begin : g_pad
        assign v = {{(LEAVES - N_IN){1'b0}}, in};
      end
    end else begin : g_node
      for (genvar j = 0; j < (LEAVES >> l); j++) begin : g_mux
        assign v[j] = sel[l-1] ? g_lvl[l-1].v[2*j+1] : g_lvl[l-1].v[2*j];
      end
    end
  end

  assign sel_err = ({1'b0, sel} >= N_LIM);
  assign out     = sel_err ? 1'b0 : g_lvl[SEL_W].v[0];

endmodule

// File: rtl/mux_b.sv
// Bit-select multiplexer with combinational and registered outputs.
// Ports:
//   clk     rising-edge clock for the registered path
//   rst_n   asynchronous active-low reset (clears out_q only)
//   in      [N_IN-1:0]  packed data word
//   sel     [SEL_W-1:0] index of the bit to route
//   out     combinational selected bit (valid during reset)
//   out_q   out registered once per clock, 1 cycle latency
//   sel_err combinational, high when sel >= N_IN
module mux_b
  import mux_pkg::*;
#(
  parameter int unsigned N_IN  = MUX_N_IN_DEFAULT,
  parameter int unsigned SEL_W = MUX_SEL_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  in,
  input  logic [SEL_W-1:0] sel,
  output logic             out,
  output logic             out_q,
  output logic             sel_err
);

  if (N_IN < 2 || N_IN > 256) begin : g_bad_n
    $error("mux_b: N_IN must be in 2..256");
  end
  if (SEL_W != mux_sel_width(N_IN)) begin : g_bad_w
    $error("mux_b: SEL_W must equal ceil(log2(N_IN))");
  end

  logic out_d;
  logic out_q_q;

  mux_tree #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_tree (
    .in      (in),
    .sel     (sel),
    .out     (out_d),
    .sel_err (sel_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_q <= 1'b0;
    end else begin
      out_q_q <= out_d;
    end
  end

  assign out   = out_d;
  assign out_q = out_q_q;

endmodule

// File: tb/tb_mux_b.sv
module tb_mux_b;
  import mux_pkg::*;

  localparam int unsigned NA = 16;
  localparam int unsigned WA = mux_sel_width(NA);
  localparam int unsigned NB = 10;
  localparam int unsigned WB = mux_sel_width(NB);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NA-1:0] in_a;
  logic [WA-1:0] sel_a;
  logic          out_a, out_q_a, err_a;
  logic [NB-1:0] in_b;
  logic [WB-1:0] sel_b;
  logic          out_b, out_q_b, err_b;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  mux_b #(.N_IN(NA), .SEL_W(WA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .sel(sel_a),
    .out(out_a), .out_q(out_q_a), .sel_err(err_a)
  );

  mux_b #(.N_IN(NB), .SEL_W(WB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .sel(sel_b),
    .out(out_b), .out_q(out_q_b), .sel_err(err_b)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: bit s of the word if s addresses a real input, else 0.
  function automatic logic ref_bit(input logic [255:0] w, input int unsigned n,
                                   input int unsigned s);
    return (s < n) ? w[s] : 1'b0;
  endfunction

  function automatic logic ref_err(input int unsigned n, input int unsigned s);
    return (s >= n);
  endfunction

  logic exp_qa, exp_qb;

  initial begin
    rst_n = 1'b0;
    in_a  = 16'h3F0A;
    sel_a = '0;
    in_b  = '0;
    sel_b = '0;

    // Combinational select while held in reset
    #1;
    check("rst_out_q_a", out_q_a, 1'b0);
    check("rst_out_q_b", out_q_b, 1'b0);
    sel_a = 4'h0; #1; check("cmb_sel0", out_a, 1'b0); check("cmb_err0", err_a, 1'b0);
    sel_a = 4'h1; #1; check("cmb_sel1", out_a, 1'b1); check("cmb_err1", err_a, 1'b0);
    sel_a = 4'h6; #1; check("cmb_sel6", out_a, 1'b0); check("cmb_err6", err_a, 1'b0);
    sel_a = 4'hC; #1; check("cmb_selC", out_a, 1'b1); check("cmb_errC", err_a, 1'b0);

    // Walking one / walking zero sweeps
    for (int k = 0; k < 16; k++) begin
      for (int s = 0; s < 16; s++) begin
        in_a  = 16'(32'd1 << k);
        sel_a = 4'(s);
        #1;
        check("walk1", out_a, (s == k));
        in_a = ~in_a;
        #1;
        check("walk0", out_a, (s != k));
        check("walk_err", err_a, 1'b0);
      end
    end

    // Registered path
    @(negedge clk);
    rst_n = 1'b1;
    in_a  = 16'h8000;
    sel_a = 4'hF;
    #1; check("reg_out_imm", out_a, 1'b1);
    @(posedge clk); #1; check("reg_q_n", out_q_a, 1'b1);
    @(negedge clk);
    sel_a = 4'h0;
    #1; check("reg_out_sel0", out_a, 1'b0);
    check("reg_q_hold", out_q_a, 1'b1);
    @(posedge clk); #1; check("reg_q_n1", out_q_a, 1'b0);

    // Async reset between edges
    @(negedge clk);
    sel_a = 4'hF;
    @(posedge clk); #1; check("ar_q_set", out_q_a, 1'b1);
    #2; rst_n = 1'b0;
    #1; check("ar_q_clr", out_q_a, 1'b0);
    check("ar_out_live", out_a, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1; check("ar_q_wait", out_q_a, 1'b0);
    @(posedge clk); #1; check("ar_q_load", out_q_a, 1'b1);

    // Non-power-of-two build
    in_b = 10'h3FF;
    sel_b = 4'd9;  #1; check("np2_out9", out_b, 1'b1);  check("np2_err9", err_b, 1'b0);
    sel_b = 4'd10; #1; check("np2_out10", out_b, 1'b0); check("np2_err10", err_b, 1'b1);
    sel_b = 4'd15; #1; check("np2_out15", out_b, 1'b0); check("np2_err15", err_b, 1'b1);

    // Randomized traffic with occasional mid-cycle reset
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      in_a  = 16'($urandom);
      sel_a = 4'($urandom);
      in_b  = 10'($urandom);
      sel_b = 4'($urandom);
      #1;
      check("rnd_out_a", out_a, ref_bit(256'(in_a), NA, sel_a));
      check("rnd_err_a", err_a, ref_err(NA, sel_a));
      check("rnd_out_b", out_b, ref_bit(256'(in_b), NB, sel_b));
      check("rnd_err_b", err_b, ref_err(NB, sel_b));
      exp_qa = ref_bit(256'(in_a), NA, sel_a);
      exp_qb = ref_bit(256'(in_b), NB, sel_b);
      @(posedge clk); #1;
      check("rnd_q_a", out_q_a, exp_qa);
      check("rnd_q_b", out_q_b, exp_qb);
      if ($urandom_range(0, 15) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rnd_rst_a", out_q_a, 1'b0);
        check("rnd_rst_b", out_q_b, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
